// File: rtl/gpr_pkg.sv
// gpr_pkg: shared state encoding, default parameters and byte-strobe merge for the GPR file
package gpr_pkg;
  typedef enum logic {CLEAR, RUN} gpr_state_e;
  localparam int GPR_DATA_W = 32;
  localparam int GPR_DEPTH = 32;
  localparam int GPR_RD_PORTS = 2;
  localparam int GPR_WR_PORTS = 1;
  localparam int GPR_ZERO_REG = 1;
  localparam int GPR_MAX_W = 256;
  localparam int GPR_MAX_B = GPR_MAX_W / 8;
  function automatic logic [GPR_MAX_W-1:0] strb_merge(
    input logic [GPR_MAX_W-1:0] old_w,
    input logic [GPR_MAX_W-1:0] new_w,
    input logic [GPR_MAX_B-1:0] strb
  );
    for (int b = 0; b < GPR_MAX_B; b++)
      strb_merge[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
  endfunction
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register busy bits with issue set, writeback release and forwarded release on reads
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int DEPTH = GPR_DEPTH,
  parameter int RD_PORTS = GPR_RD_PORTS,
  parameter int WR_PORTS = GPR_WR_PORTS,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_en,
  input  logic [ADDR_W-1:0]            set_addr,
  input  logic [WR_PORTS-1:0]          rel_en,
  input  logic [WR_PORTS*ADDR_W-1:0]   rel_addr,
  input  logic                         clr_all,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS-1:0]          rd_busy
);
  logic [DEPTH-1:0] busy;
  // set is applied after release so a same-cycle issue wins
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else if (clr_all) busy <= '0;
    else begin
      for (int w = 0; w < WR_PORTS; w++)
        if (rel_en[w]) busy[rel_addr[w*ADDR_W +: ADDR_W]] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_busy[p] = busy[rd_addr[p*ADDR_W +: ADDR_W]];
      for (int w = 0; w < WR_PORTS; w++)
        if (rel_en[w] && rel_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W]) rd_busy[p] = 1'b0;
    end
  end
endmodule

// File: rtl/gpr_file.sv
// gpr_file: multi-port register file with byte strobes, write forwarding, busy scoreboard and sweep clear
module gpr_file
  import gpr_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int DEPTH = GPR_DEPTH,
  parameter int RD_PORTS = GPR_RD_PORTS,
  parameter int WR_PORTS = GPR_WR_PORTS,
  parameter int ZERO_REG = GPR_ZERO_REG,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RD_PORTS*ADDR_W-1:0]     rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]     rd_data,
  output logic [RD_PORTS-1:0]            rd_busy,
  input  logic [WR_PORTS-1:0]            wr_we_,
  input  logic [WR_PORTS*ADDR_W-1:0]     wr_addr,
  input  logic [WR_PORTS*DATA_W-1:0]     wr_data,
  input  logic [WR_PORTS*DATA_W/8-1:0]   wr_strb,
  input  logic [WR_PORTS-1:0]            wr_rel,
  input  logic                           iss_valid,
  input  logic [ADDR_W-1:0]              iss_addr,
  input  logic                           clr_req,
  output logic                           ready
);
  localparam int STRB_W = DATA_W / 8;
  gpr_state_e state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic run;
  logic [WR_PORTS-1:0] wen;
  logic [WR_PORTS*DATA_W-1:0] wr_val;
  logic [RD_PORTS-1:0] sb_busy;
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG != 0 && a == '0;
  endfunction
  assign run = state == RUN;
  assign ready = run;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      ptr <= '0;
    end else if (!run) begin
      ptr <= ptr + ADDR_W'(1);
      if (ptr == ADDR_W'(DEPTH - 1)) state <= RUN;
    end else if (clr_req) begin
      state <= CLEAR;
      ptr <= '0;
    end
  always_comb begin
    wen = '0;
    for (int w = 0; w < WR_PORTS; w++)
      wen[w] = run && !wr_we_[w] && !is_zero(wr_addr[w*ADDR_W +: ADDR_W]);
  end
  // each port's value folds in lower ports to the same address, so the last writer carries the full merge
  always_comb begin
    wr_val = '0;
    for (int w = 0; w < WR_PORTS; w++) begin
      wr_val[w*DATA_W +: DATA_W] = mem[wr_addr[w*ADDR_W +: ADDR_W]];
      for (int u = 0; u <= w; u++)
        if (wen[u] && wr_addr[u*ADDR_W +: ADDR_W] == wr_addr[w*ADDR_W +: ADDR_W])
          wr_val[w*DATA_W +: DATA_W] = DATA_W'(strb_merge(GPR_MAX_W'(wr_val[w*DATA_W +: DATA_W]),
            GPR_MAX_W'(wr_data[u*DATA_W +: DATA_W]), GPR_MAX_B'(wr_strb[u*STRB_W +: STRB_W])));
    end
  end
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_data[p*DATA_W +: DATA_W] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
      for (int u = 0; u < WR_PORTS; u++)
        if (wen[u] && wr_addr[u*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])
          rd_data[p*DATA_W +: DATA_W] = DATA_W'(strb_merge(GPR_MAX_W'(rd_data[p*DATA_W +: DATA_W]),
            GPR_MAX_W'(wr_data[u*DATA_W +: DATA_W]), GPR_MAX_B'(wr_strb[u*STRB_W +: STRB_W])));
      if (!run || is_zero(rd_addr[p*ADDR_W +: ADDR_W])) rd_data[p*DATA_W +: DATA_W] = '0;
    end
  end
  // storage has no reset; the CLEAR sweep is what zeroes it
  always_ff @(posedge clk)
    if (!run) mem[ptr] <= '0;
    else
      for (int w = 0; w < WR_PORTS; w++)
        if (wen[w]) mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_val[w*DATA_W +: DATA_W];
  gpr_scoreboard #(
    .DEPTH(DEPTH),
    .RD_PORTS(RD_PORTS),
    .WR_PORTS(WR_PORTS),
    .ADDR_W(ADDR_W)
  ) u_sb (
    .clk(clk),
    .rst(rst),
    .set_en(run && iss_valid && !is_zero(iss_addr)),
    .set_addr(iss_addr),
    .rel_en(wen & wr_rel),
    .rel_addr(wr_addr),
    .clr_all(!run || clr_req),
    .rd_addr(rd_addr),
    .rd_busy(sb_busy)
  );
  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < RD_PORTS; p++)
      rd_busy[p] = sb_busy[p] && run && !is_zero(rd_addr[p*ADDR_W +: ADDR_W]);
  end
endmodule

// File: doc/gpr_file.md
# gpr_file

Parametrised multi-port general-purpose register file for the CPU core, successor to the fixed 2-read/1-write GPR. It adds configurable width, depth and port counts, per-byte write strobes, write-to-read forwarding with byte merge, and an optional hardwired zero register. It also provides a busy scoreboard for hazard detection and a sweep-clear state machine, so storage needs no reset and maps onto RAM-like cells. It sits between decode/issue (read ports, scoreboard set) and writeback (write ports, scoreboard release).

## Interface
- DATA_W, 32, register width in bits; multiple of 8
- DEPTH, 32, number of registers; power of two, ≥ 4
- RD_PORTS, 2, number of read ports
- WR_PORTS, 1, number of write ports
- ZERO_REG, 1, 1: register 0 always reads 0, is never busy, and ignores writes
- ADDR_W, $clog2(DEPTH), derived; not overridden
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  RD_PORTS*ADDR_W  read addresses, port p at slice p
- rd_data  out  RD_PORTS*DATA_W  read data, combinational
- rd_busy  out  RD_PORTS  register at rd_addr[p] has a pending producer
- wr_we_  in  WR_PORTS  write enable per port, active-low
- wr_addr  in  WR_PORTS*ADDR_W  write addresses
- wr_data  in  WR_PORTS*DATA_W  write data
- wr_strb  in  WR_PORTS*DATA_W/8  byte strobes, 1 = byte written
- wr_rel  in  WR_PORTS  write also releases the busy bit of wr_addr
- iss_valid  in  1  issue marks iss_addr busy
- iss_addr  in  ADDR_W  destination being issued
- clr_req  in  1  pulse: re-clear whole file
- ready  out  1  file operational (state RUN)

## Operation
- FSM states CLEAR, RUN. Reset (asynchronous): state=CLEAR, ptr=0, all busy=0.
- CLEAR: one register per cycle, mem[ptr] ← 0, ptr++. When ptr==DEPTH-1, the next state is RUN. Writes, issues and clr_req are ignored. rd_data=0, rd_busy=0, ready=0.
- RUN: ready=1. clr_req → CLEAR (ptr=0, all busy cleared at the same edge).
- Write: for each port with wr_we_==0, the bytes with strobe=1 are updated at the edge. If several ports target the same address, the highest port index wins per byte.
- Read: rd_data[p] = mem[rd_addr[p]], with every same-cycle enabled write to that address merged per byte in priority order (forwarding).
- ZERO_REG=1 and address 0: read 0, write dropped, iss/rel ignored, rd_busy=0.
- Scoreboard: iss_valid sets busy[iss_addr]. An enabled write with wr_rel clears busy[wr_addr]. If set and clear hit the same address in the same cycle, set wins.
- rd_busy[p] = busy[rd_addr[p]] and not (same-cycle releasing write to rd_addr[p]). Release is forwarded exactly like data.
- A write with wr_rel to a non-busy register is legal; the busy bit stays 0.

## Timing
- Read data and rd_busy: 0-cycle latency (combinational from addresses and write ports).
- Write visible in storage from the cycle after the edge; visible at read in the same cycle through forwarding.
- ready rises exactly DEPTH cycles after reset deasserts, and DEPTH cycles after the edge that samples clr_req.
- Reset asserted mid-CLEAR or mid-RUN: immediate return to CLEAR, ptr=0, ready=0. The sweep restarts in full.
- clr_req held high in CLEAR has no effect. Held into RUN, it triggers a new sweep.
- Storage has no reset term; correctness after reset relies only on the sweep.

## Structure
- Package gpr_pkg: state enum gpr_state_e {CLEAR, RUN}; default parameter constants; a strobe-merge function (old, new, strb) → merged word.
- Sub-module gpr_scoreboard: DEPTH busy bits, set/release/clear-all inputs, RD_PORTS forwarded busy outputs. Storage, forwarding and FSM stay in gpr_file.

## Test plan
- Reset then idle → ready=0 for 32 cycles, 1 on cycle 32; all registers read 0x00000000.
- Write reg 5 = 0xDEADBEEF, strb=4'b1111, read reg 5 in the same cycle → rd_data=0xDEADBEEF; next cycle the stored value matches. Then write 0x000000AA with strb=4'b0001 → 0xDEADBEAA.
- WR_PORTS=2, both ports write reg 7 (0x11111111, 0x22222222), strb full → 0x22222222. Port1 strb=4'b0011 → 0x11112222.
- Issue reg 3 → rd_busy=1 next cycle. A releasing write to reg 3 → rd_busy=0 in the same cycle. Issue and release of reg 3 together → busy stays 1.
- ZERO_REG=1: write 0xFFFFFFFF to reg 0 and issue reg 0 → reads 0, rd_busy=0.
- Assert rst at sweep cycle 10, or pulse clr_req in RUN with regs and busy bits set → ready low for 32 cycles; all regs 0, all busy 0; writes during CLEAR are lost.
